// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s core slice: fetch scheduler state encoding.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BRANCH_WAIT
  } fetch_sched_state_e;

endpackage

// File: rtl/cv32e40s_fetch_sched_cnt.sv
// Up/down counter of bus transactions accepted by the prefetcher but not yet answered.
module cv32e40s_fetch_sched_cnt #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         dec_ok;

  // A response with nothing outstanding is ignored rather than wrapping the count.
  assign dec_ok = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_ok) begin
      cnt_d = cnt_q + W'(1);
    end else if (!inc_i && dec_ok) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) dec_i |-> (cnt_q != '0));
  a_no_overflow  : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= W'(MAX));

endmodule

// File: rtl/cv32e40s_fetch_scheduler.sv
// Gates prefetcher requests so the fetch FIFO never overflows and drops responses made stale by branches.
// Optional discard counter output is enabled by defining CV32E40S_FETCH_SCHED_PERF_EN.
module cv32e40s_fetch_scheduler
  import cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH           = 3,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned FIFO_W         = $clog2(DEPTH + 1),
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              branch_i,
  output logic              pf_valid_o,
  input  logic              pf_ready_i,
  input  logic              resp_valid_i,
  output logic              resp_valid_o,
  input  logic [FIFO_W-1:0] fifo_cnt_i,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              busy_o
`ifdef CV32E40S_FETCH_SCHED_PERF_EN
  ,
  output logic [31:0]       discard_cnt_o
`endif
);

  localparam int unsigned SUM_W = ((FIFO_W > CNT_W) ? FIFO_W : CNT_W) + 1;

  fetch_sched_state_e state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   discard_q;
  logic [CNT_W-1:0]   discard_d;
  logic [CNT_W-1:0]   live;
  logic [FIFO_W-1:0]  level;
  logic [SUM_W-1:0]   occupancy;
  logic               below_max;
  logic               room;
  logic               accept;
  logic               resp_dec;

  cv32e40s_fetch_sched_cnt #(
    .MAX (MAX_OUTSTANDING),
    .W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (accept),
    .dec_i (resp_valid_i),
    .cnt_o (cnt_q)
  );

  // A branch flushes the FIFO, so everything in flight stops counting against it.
  assign live      = branch_i ? '0 : (cnt_q - discard_q);
  assign level     = branch_i ? '0 : fifo_cnt_i;
  assign occupancy = SUM_W'(level) + SUM_W'(live);
  assign below_max = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign room      = below_max && (occupancy < SUM_W'(DEPTH));

  always_comb begin
    pf_valid_o = 1'b0;
    case (state_q)
      IDLE:        pf_valid_o = branch_i ? below_max : (req_i && room);
      RUN:         pf_valid_o = req_i && room;
      BRANCH_WAIT: pf_valid_o = below_max;
      default:     pf_valid_o = 1'b0;
    endcase
  end

  assign accept       = pf_valid_o && pf_ready_i;
  assign resp_dec     = resp_valid_i && (cnt_q != '0);
  assign resp_valid_o = resp_valid_i && !branch_i && (discard_q == '0);
  assign busy_o       = (cnt_q != '0) || (state_q != IDLE);
  assign outstanding_o = cnt_q;

  // The target fetch accepted in the branch cycle is never counted as a discard.
  always_comb begin
    if (branch_i) begin
      discard_d = cnt_q - CNT_W'(resp_dec);
    end else begin
      discard_d = discard_q - CNT_W'(resp_valid_i && (discard_q != '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
      case (state_q)
        IDLE: begin
          if (branch_i) begin
            state_q <= accept ? (req_i ? RUN : IDLE) : BRANCH_WAIT;
          end else if (req_i && room) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (branch_i) begin
            state_q <= accept ? RUN : BRANCH_WAIT;
          end else if (!req_i) begin
            state_q <= IDLE;
          end
        end
        BRANCH_WAIT: begin
          if (accept) begin
            state_q <= req_i ? RUN : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CV32E40S_FETCH_SCHED_PERF_EN
  logic [31:0] discard_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt_q <= '0;
    end else if (resp_valid_i && !resp_valid_o && (discard_cnt_q != 32'hFFFF_FFFF)) begin
      discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign discard_cnt_o = discard_cnt_q;
`endif

endmodule
